// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared single-cycle ALU
// Optional macro ALU_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module alu_arbiter #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic [2:0]   req0_op,
   input  logic [2:0]   req1_op,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [2:0]   alu_op,
   input  logic [W-1:0] alu_z,
   input  logic         alu_cout,
   input  logic         alu_sign,
   input  logic         alu_ov,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_z,
   output logic [2:0]   rsp_flags
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t     state;
   logic [1:0] grant;
   logic       grant_id;
   logic       cur_id;
   logic       handshake;

`ifndef ALU_ARB_FIXED_PRIO_EN
   logic       last_grant;
`endif

   // Grant is combinational so a lone requester is accepted in its first valid cycle.
   always_comb begin
      grant = 2'b00;
      if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         grant = 2'b01;
`else
         grant = last_grant ? 2'b01 : 2'b10;
`endif
      end else if (req_valid[0]) begin
         grant = 2'b01;
      end else if (req_valid[1]) begin
         grant = 2'b10;
      end
   end

   assign req_ready = (state == IDLE) ? grant : 2'b00;
   assign grant_id  = grant[1];
   assign handshake = |(req_valid & req_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cur_id    <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= 3'd0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_z     <= '0;
         rsp_flags <= 3'b000;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last_grant <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  // ALU operand registers double as the operand latch and hold after issue.
                  alu_a  <= grant_id ? req1_a  : req0_a;
                  alu_b  <= grant_id ? req1_b  : req0_b;
                  alu_op <= grant_id ? req1_op : req0_op;
                  cur_id <= grant_id;
`ifndef ALU_ARB_FIXED_PRIO_EN
                  last_grant <= grant_id;
`endif
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               rsp_z     <= alu_z;
               rsp_flags <= {alu_cout, alu_sign, alu_ov};
               rsp_id    <= cur_id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed scoreboard bench for alu_arbiter
// Honours ALU_ARB_FIXED_PRIO_EN for the expected tie-break order.
module tb_alu_arbiter;
   localparam int W = 12;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]   req0_op, req1_op;
   logic [W-1:0] alu_a, alu_b, alu_z;
   logic [2:0]   alu_op;
   logic         alu_cout, alu_sign, alu_ov;
   logic         rsp_valid, rsp_ready, rsp_id;
   logic [W-1:0] rsp_z;
   logic [2:0]   rsp_flags;

   int checks   = 0;
   int failures = 0;
   logic [15:0] sb_q[$];

   always #5 clk = ~clk;

   alu_arbiter #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_op(req0_op), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_z(alu_z), .alu_cout(alu_cout), .alu_sign(alu_sign), .alu_ov(alu_ov),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_z(rsp_z), .rsp_flags(rsp_flags)
   );

   // Reference ALU: returns {cout, sign, ov, z}; op 6 add, op 7 subtract, else xor.
   function automatic logic [14:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op);
      logic [W:0]   s;
      logic [W-1:0] bb;
      logic         ov;
      if (op == 3'd6 || op == 3'd7) begin
         bb = (op == 3'd7) ? ~b : b;
         s  = {1'b0, a} + {1'b0, bb} + ((op == 3'd7) ? 13'd1 : 13'd0);
         ov = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
      end else begin
         s  = {1'b0, a ^ b};
         ov = 1'b0;
      end
      return {s[W], s[W-1], ov, s[W-1:0]};
   endfunction

   logic [14:0] alu_res;
   assign alu_res = alu_fn(alu_a, alu_b, alu_op);
   assign {alu_cout, alu_sign, alu_ov, alu_z} = alu_res;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag);
      logic [15:0] e;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk(tag, {16'd0, rsp_id, rsp_flags, rsp_z}, {16'd0, e});
      end
   endtask

   // One isolated op from requester id; response held back for hold cycles.
   task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input int hold);
      logic [15:0] snap;
      rsp_ready = 1'b0;
      if (id == 1) begin req1_a = a; req1_b = b; req1_op = op; req_valid = 2'b10; end
      else         begin req0_a = a; req0_b = b; req0_op = op; req_valid = 2'b01; end
      #1;
      chk("grant_same_cycle", {30'd0, req_ready}, (id == 1) ? 32'd2 : 32'd1);
      sb_q.push_back({id[0], alu_fn(a, b, op)});
      @(negedge clk);
      req_valid = 2'b00;
      chk("issue_alu_op", {29'd0, alu_op}, {29'd0, op});
      chk("issue_alu_ab", {8'd0, alu_a, alu_b}, {8'd0, a, b});
      chk("issue_no_rsp", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("rsp_valid_n2", {31'd0, rsp_valid}, 32'd1);
      pop_chk("rsp_payload");
      snap = {rsp_id, rsp_flags, rsp_z};
      req_valid = (hold > 0) ? 2'b11 : 2'b00;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         #1;
         chk("bp_stable", {16'd0, rsp_id, rsp_flags, rsp_z}, {16'd0, snap});
         chk("bp_ready_zero", {30'd0, req_ready}, 32'd0);
         chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
      end
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("idle_after_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("alu_op_held", {29'd0, alu_op}, {29'd0, op});
   endtask

   initial begin
      logic [W-1:0] a0, b0, a1, b1;
      int exp_id;
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_op = 3'd0; req1_op = 3'd0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp", {16'd0, rsp_id, rsp_flags, rsp_z}, 32'd0);
      chk("rst_alu", {5'd0, alu_a, alu_b, alu_op}, 32'd0);

      // Single op from requester 0, then constant checks on its result.
      do_op(0, 12'h005, 12'h003, 3'd6, 0);
      chk("single_z", {20'd0, rsp_z}, 32'h008);
      chk("single_flags", {29'd0, rsp_flags}, 32'd0);
      chk("single_id", {31'd0, rsp_id}, 32'd0);

      // Overflow op from requester 1 with 5 cycles of backpressure.
      do_op(1, 12'h7FF, 12'h001, 3'd6, 5);
      chk("ovf_z", {20'd0, rsp_z}, 32'h800);
      chk("ovf_flags", {29'd0, rsp_flags}, 32'b011);
      chk("ovf_id", {31'd0, rsp_id}, 32'd1);

      // Idle cycles must not move the last-grant pointer.
      repeat (3) @(negedge clk);

      // Tie: both requesters hold valid, responses consumed immediately.
      a0 = 12'h100; b0 = 12'h023; a1 = 12'h0F0; b1 = 12'h00F;
      req0_a = a0; req0_b = b0; req0_op = 3'd6;
      req1_a = a1; req1_b = b1; req1_op = 3'd7;
      rsp_ready = 1'b1;
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
         exp_id = 0;
`else
         exp_id = i % 2;
`endif
         chk($sformatf("tie_grant%0d", i), {30'd0, req_ready}, (exp_id == 1) ? 32'd2 : 32'd1);
         sb_q.push_back((exp_id == 1) ? {1'b1, alu_fn(a1, b1, 3'd7)} : {1'b0, alu_fn(a0, b0, 3'd6)});
         @(negedge clk);
         chk("tie_issue_ready", {30'd0, req_ready}, 32'd0);
         @(negedge clk);
         chk("tie_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("tie_resp_ready", {30'd0, req_ready}, 32'd0);
         pop_chk("tie_rsp");
         @(negedge clk);
      end
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      @(negedge clk);

      // Reset during ISSUE aborts the op.
      req0_a = 12'h001; req0_b = 12'h001; req0_op = 3'd6; req_valid = 2'b01;
      #1;
      chk("abort_grant", {30'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 2'b00;
      chk("abort_issue_op", {29'd0, alu_op}, 32'd6);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b1;
      chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("abort_alu_cleared", {5'd0, alu_a, alu_b, alu_op}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
      end
      rsp_ready = 1'b0;

      // Recovery after abort.
      do_op(1, 12'h0A5, 12'h05A, 3'd2, 0);
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: W, 12, operand/result width; SHALL match the shared ALU datapath width.
REQ-002 Ports (clock and reset first):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester request accepted.
- req0_a, req0_b  in  W  requester 0 operands.
- req1_a, req1_b  in  W  requester 1 operands.
- req0_op, req1_op  in  3  requester opcodes.
- alu_a, alu_b  out  W  operands to the shared ALU.
- alu_op  out  3  opcode to the shared ALU.
- alu_z  in  W  ALU result.
- alu_cout, alu_sign, alu_ov  in  1  ALU flags.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_id  out  1  requester the response belongs to.
- rsp_z  out  W  captured result.
- rsp_flags  out  3  captured {cout, sign, ov}.
REQ-003 Single clock domain; all state SHALL update on the rising edge of clk only.

Function
REQ-004 FSM states: IDLE, ISSUE, RESP; at most one operation outstanding.
REQ-005 IDLE: req_ready SHALL be one-hot to the granted requester when any req_valid is high, else 2'b00; a handshake is req_valid[i] & req_ready[i].
REQ-006 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; a single requester SHALL be granted immediately.
REQ-007 On handshake in cycle N: latch operands, opcode and id; go to ISSUE in N+1.
REQ-008 ISSUE: alu_a/alu_b/alu_op SHALL present latched values; at end of cycle N+1 capture alu_z and flags; go to RESP.
REQ-009 RESP: rsp_valid=1 from cycle N+2; rsp_id/rsp_z/rsp_flags SHALL be stable until rsp_valid & rsp_ready.
REQ-010 On rsp_valid & rsp_ready, return to IDLE; the next grant SHALL occur no earlier than the following cycle (min 3 cycles per op).
REQ-011 req_ready SHALL be 2'b00 in ISSUE and RESP; requests held there wait, not drop.
REQ-012 alu_a/alu_b/alu_op SHALL hold the last issued values outside ISSUE (no glitching to zero).
REQ-013 Last-grant pointer SHALL update only on a handshake, not on idle cycles.
REQ-014 Requester deasserting req_valid before handshake SHALL not be granted or counted.

Reset
REQ-015 rst=1 at a clock edge SHALL force IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_z=0, rsp_flags=0, alu_a=0, alu_b=0, alu_op=0, last-grant=1 (so requester 0 wins first tie).
REQ-016 Reset asserted in ISSUE or RESP SHALL abort the operation with no response produced.

Configuration
REQ-017 Macro ALU_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority (requester 0 always wins ties) and the last-grant pointer SHALL not be implemented; when undefined, round-robin per REQ-006.

Verification
REQ-018 Single op: after reset, req0 valid A=12'h005 B=12'h003 op=6 -> req_ready=2'b01 same cycle, alu_op=6 next cycle, rsp_valid two cycles after handshake, rsp_id=0, rsp_z=12'h008, flags=3'b000.
REQ-019 Tie: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 (with ALU_ARB_FIXED_PRIO_EN: 0,0,0,0).
REQ-020 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=2'b00 throughout; release -> IDLE next cycle.
REQ-021 Overflow flags: req1 A=12'h7FF B=12'h001 op=6 -> rsp_z=12'h800, rsp_flags={0,1,1}, rsp_id=1.
REQ-022 Reset mid-op: rst in ISSUE -> next cycle IDLE, rsp_valid=0, no response ever for that op.
